// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Holds the add/sub primitive it drives as its only arithmetic element.
module subtractor #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  // a - b computed as a + ~b + cin; cout=1 means no borrow
  assign {cout, sum} = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
endmodule

module seq_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         ready,
  output logic         valid,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [N-1:0]  q_r;
  logic [N-1:0]  r_r;
  logic [N-1:0]  d_r;
  logic [CW-1:0] cnt;

  logic [N:0]    s;
  logic [N:0]    diff;
  logic          cout;
  logic [N-1:0]  q_nxt;
  logic [N-1:0]  r_nxt;

  assign s = {r_r, q_r[N-1]};

  subtractor #(
    .W(N + 1)
  ) u_sub (
    .a   (s),
    .b   ({1'b0, d_r}),
    .cin (1'b1),
    .sum (diff),
    .cout(cout)
  );

  assign q_nxt = {q_r[N-2:0], cout};
  assign r_nxt = cout ? diff[N-1:0] : s[N-1:0];
  assign ready = (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      q_r         <= '0;
      r_r         <= '0;
      d_r         <= '0;
      cnt         <= '0;
      valid       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            q_r         <= dividend;
            d_r         <= divisor;
            r_r         <= '0;
            cnt         <= '0;
            div_by_zero <= (divisor == '0);
            // zero divisor skips the iteration entirely
            if (divisor == '0) begin
              state     <= DONE;
              valid     <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
            end else begin
              state <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          q_r <= q_nxt;
          r_r <= r_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            valid     <= 1'b1;
            quotient  <= q_nxt;
            remainder <= r_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=32): results, latency,
// divide-by-zero, start-while-busy, back-to-back and mid-run reset.
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        ready;
  logic        valid;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  int lat;
  int seen;

  seq_divider #(.N(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .valid      (valid),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for valid after the accepting edge; lat counts edges incl. it.
  task automatic wait_valid(inout int l);
    while (!valid && l < 40) begin
      chk("ready_busy", {31'd0, ready}, 32'd0);
      tick();
      l++;
    end
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        output int l);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    l     = 1;
    wait_valid(l);
  endtask

  task automatic expect_res(input string tag, input int l,
                            input int el, input logic [31:0] q,
                            input logic [31:0] r, input logic z);
    chk({tag, "_lat"}, l, el);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
    chk({tag, "_q"}, quotient, q);
    chk({tag, "_r"}, remainder, r);
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, z});
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    do_div(32'd100, 32'd7, lat);
    expect_res("d100_7", lat, 33, 32'd14, 32'd2, 1'b0);
    tick();
    chk("valid_pulse", {31'd0, valid}, 32'd0);
    chk("idle_ready", {31'd0, ready}, 32'd1);

    do_div(32'd5, 32'd9, lat);
    expect_res("d5_9", lat, 33, 32'd0, 32'd5, 1'b0);
    tick();
    do_div(32'd0, 32'd9, lat);
    expect_res("d0_9", lat, 33, 32'd0, 32'd0, 1'b0);
    tick();
    do_div(32'hFFFF_FFFF, 32'd1, lat);
    expect_res("dmax_1", lat, 33, 32'hFFFF_FFFF, 32'd0, 1'b0);
    tick();
    do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    expect_res("dmax_max", lat, 33, 32'd1, 32'd0, 1'b0);
    tick();

    do_div(32'd1234, 32'd0, lat);
    expect_res("dz", lat, 1, 32'hFFFF_FFFF, 32'd1234, 1'b1);
    tick();
    chk("dz_pulse", {31'd0, valid}, 32'd0);
    chk("dz_hold", {31'd0, div_by_zero}, 32'd1);
    do_div(32'd1000, 32'd33, lat);
    expect_res("after_dz", lat, 33, 32'd30, 32'd10, 1'b0);
    tick();

    // start while busy must be ignored
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    repeat (9) begin
      tick();
      lat++;
    end
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat++;
    wait_valid(lat);
    expect_res("busy_ign", lat, 33, 32'd14, 32'd2, 1'b0);

    // back-to-back start during DONE
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!valid && lat < 40) begin
      chk("b2b_hold_q", quotient, 32'd14);
      chk("b2b_hold_r", remainder, 32'd2);
      tick();
      lat++;
    end
    expect_res("b2b", lat, 33, 32'd10, 32'd0, 1'b0);
    tick();
    tick();

    // reset in the middle of a divide
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q", quotient, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("mid_ready", {31'd0, ready}, 32'd1);
    chk("mid_valid", {31'd0, valid}, 32'd0);
    chk("mid_q", quotient, 32'd0);
    chk("mid_r", remainder, 32'd0);
    chk("mid_dbz", {31'd0, div_by_zero}, 32'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (valid) seen++;
    end
    chk("mid_no_valid", seen, 0);
    chk("mid_idle_ready", {31'd0, ready}, 32'd1);
    do_div(32'd81, 32'd9, lat);
    expect_res("d81_9", lat, 33, 32'd9, 32'd0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative unsigned restoring divider that computes quotient and remainder of two N-bit operands, one quotient bit per clock. It drives the team's `subtractor` add/sub block as its only arithmetic element. It sits directly upstream of that block: it generates A/B/Cin and consumes Sum/Cout each cycle. It is the datapath's divide unit behind a start/valid handshake.

## Interface
- N, 32, operand/result width in bits (N ≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when ready=1
- dividend  input  N  unsigned dividend, sampled on accepted start
- divisor  input  N  unsigned divisor, sampled on accepted start
- ready  output  1  high in IDLE and DONE (can accept start)
- valid  output  1  one-cycle pulse, results valid
- quotient  output  N  unsigned quotient, held until next accepted start
- remainder  output  N  unsigned remainder, held until next accepted start
- div_by_zero  output  1  set with valid when divisor was 0; held with results

## Operation
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- State machine: IDLE, RUN, DONE.
  - IDLE → RUN on start with divisor≠0.
  - IDLE → DONE on start with divisor=0.
  - RUN → DONE when the step counter reaches N-1 (after step N completes).
  - DONE → RUN or DONE on start, same rule as IDLE, which allows back-to-back operation.
  - DONE → IDLE with no start.
- On accepted start:
  - Q ← dividend, D ← divisor, R ← 0, cnt ← 0, div_by_zero ← (divisor==0).
  - quotient/remainder keep their old values until the next valid.
- RUN step, one per cycle:
  - S = {R[N-1:0], Q[N-1]} (N+1 bits).
  - `subtractor` #(N+1) is driven with A=S, B={1'b0,D}, Cin=1.
  - If Cout=1 (no borrow): R ← Sum[N-1:0], Q ← {Q[N-2:0],1}.
  - Else: R ← S[N-1:0], Q ← {Q[N-2:0],0}.
  - cnt increments each step.
- Entering DONE:
  - Normal case: quotient ← Q, remainder ← R.
  - Divide-by-zero: quotient ← all ones, remainder ← dividend, div_by_zero=1.
  - valid=1 for exactly the DONE cycle.
- start while in RUN (ready=0) is ignored: no state or operand change, no error.
- Arithmetic is unsigned only, with no overflow possible. Invariant: dividend = quotient·divisor + remainder, with remainder < divisor.

## Timing
- Reset values: state=IDLE, ready=1, valid=0, quotient=0, remainder=0, div_by_zero=0, cnt=0, and internal Q/R/D=0.
- Accepted start at edge T:
  - Normal case: valid high in cycle T+N+1, i.e. after N RUN cycles plus DONE. For N=32, latency is 33 cycles from the start edge to valid.
  - divisor=0: valid high in cycle T+1.
- ready is combinational from state: 1 in IDLE/DONE, 0 in RUN.
- valid is registered (state==DONE) and never stays high for 2 consecutive cycles without a new accepted start in between.
- Back-to-back: start accepted in DONE gives a next valid at DONE+N+1. The outputs from the first result stay stable until that second valid.
- rst_n asserted mid-RUN:
  - Immediately aborts the operation and forces all reset values.
  - No valid is produced for the aborted operation.
  - After deassertion the block is in IDLE with ready=1.
- The `subtractor` path is combinational within one cycle; the N+1-bit ripple path must meet clk period.

## Test plan
- 100/7, N=32: start at T → valid only at T+33, quotient=14, remainder=2, div_by_zero=0; ready=0 for T+1..T+32.
- 5/9 and 0/9 → quotient=0, remainder=5 and 0 respectively, latency 33.
- 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0; 0xFFFFFFFF/0xFFFFFFFF → quotient=1, remainder=0.
- 1234/0 → valid at T+1, quotient=0xFFFFFFFF, remainder=1234, div_by_zero=1. The next normal divide clears div_by_zero.
- Protocol case:
  - Start 100/7, then pulse start with 50/5 at T+10 (ignored) → result 14/2.
  - Start 50/5 during DONE → valid 33 cycles later with 10/0; 14/2 is held in between.
- Assert rst_n=0 at T+15 of a divide, release at T+17 → all outputs at reset values, no valid, ready=1. A fresh 81/9 then returns 9/0.
